// File: rtl/i2c_bit_master.sv
// Bit-level I2C master: START/rSTART/STOP and single data bits on open-drain SCL/SDA.
// Define I2C_CLK_STRETCH_EN to hold high-phase timing until slaves release SCL.
module i2c_bit_master #(
    parameter int US       = 50,
    parameter int I2C_MODE = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd,
    input  logic       din,
    output logic       dout,
    output logic       done,
    output logic       err,
    output logic       arb_lost,
    input  logic       bby,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_oe,
    output logic       sda_oe
);

    function automatic int cyc(input int t10);
        int c;
        c = (t10 * US + 9) / 10;
        return (c < 1) ? 1 : c;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int T_LOW  = cyc((I2C_MODE != 0) ? 13 : 47);
    localparam int T_HIGH = cyc((I2C_MODE != 0) ? 6 : 40);
    localparam int T_SUSA = cyc((I2C_MODE != 0) ? 6 : 47);
    localparam int T_HDSA = cyc((I2C_MODE != 0) ? 6 : 40);
    localparam int T_SUSO = cyc((I2C_MODE != 0) ? 6 : 40);
    localparam int T_BUF  = cyc((I2C_MODE != 0) ? 13 : 47);
    localparam int T_MAX  = max2(max2(max2(T_LOW, T_HIGH), max2(T_SUSA, T_HDSA)),
                                 max2(T_SUSO, T_BUF));
    localparam int CW     = $clog2(T_MAX) + 1;

    typedef logic [CW-1:0] cnt_t;

    function automatic cnt_t ld(input int n);
        return cnt_t'(n - 1);
    endfunction

    localparam logic [1:0] C_START = 2'd0;
    localparam logic [1:0] C_STOP  = 2'd1;
    localparam logic [1:0] C_WRITE = 2'd2;
    localparam logic [1:0] C_READ  = 2'd3;

    typedef enum logic [3:0] {
        IDLE, STA_SU, STA_HD, OWN, BIT_LO, BIT_HI, STO_LO, STO_SU, STO_BUF
    } state_t;

    state_t state, state_n;
    cnt_t   cnt, cnt_n;
    logic   scl_n, sda_n, done_n, err_n, arb_n, dout_n;
    logic   rd, rd_n, rs, rs_n, rdy_r, rdy_n;
    logic   last, hi_ok, arb_hit, accept;

`ifdef I2C_CLK_STRETCH_EN
    assign hi_ok = scl_i;
`else
    assign hi_ok = 1'b1;
`endif

    assign last      = (cnt == '0);
    assign arb_hit   = ~sda_oe & ~sda_i & scl_i;
    assign cmd_ready = rdy_r & ~((state == IDLE) & bby);
    assign accept    = cmd_valid & cmd_ready;

    always_comb begin
        state_n = state;
        cnt_n   = last ? cnt : cnt - cnt_t'(1);
        scl_n   = scl_oe;
        sda_n   = sda_oe;
        done_n  = 1'b0;
        err_n   = 1'b0;
        arb_n   = 1'b0;
        dout_n  = dout;
        rd_n    = rd;
        rs_n    = rs;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (cmd == C_START) begin
                        state_n = STA_SU;
                        cnt_n   = ld(T_SUSA);
                        scl_n   = 1'b0;
                        sda_n   = 1'b0;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            STA_SU: begin
                if (!hi_ok) cnt_n = cnt;
                if (arb_hit) begin
                    state_n = IDLE;
                    arb_n   = 1'b1;
                end else if (last && hi_ok) begin
                    state_n = STA_HD;
                    cnt_n   = ld(T_HDSA);
                    sda_n   = 1'b1;
                end
            end
            STA_HD: begin
                if (last) begin
                    state_n = OWN;
                    scl_n   = 1'b1;
                    done_n  = 1'b1;
                end
            end
            OWN: begin
                if (accept) begin
                    cnt_n = ld(T_LOW);
                    rs_n  = 1'b0;
                    rd_n  = 1'b0;
                    unique case (1'b1)
                        cmd == C_START: begin
                            state_n = BIT_LO;
                            sda_n   = 1'b0;
                            rs_n    = 1'b1;
                        end
                        cmd == C_STOP: begin
                            state_n = STO_LO;
                            sda_n   = 1'b1;
                        end
                        cmd == C_WRITE: begin
                            state_n = BIT_LO;
                            sda_n   = ~din;
                        end
                        cmd == C_READ: begin
                            state_n = BIT_LO;
                            sda_n   = 1'b0;
                            rd_n    = 1'b1;
                        end
                        default: state_n = OWN;
                    endcase
                end
            end
            BIT_LO: begin
                if (last) begin
                    scl_n   = 1'b0;
                    state_n = rs ? STA_SU : BIT_HI;
                    cnt_n   = rs ? ld(T_SUSA) : ld(T_HIGH);
                end
            end
            BIT_HI: begin
                if (!hi_ok) cnt_n = cnt;
                if (arb_hit && !rd) begin
                    state_n = IDLE;
                    arb_n   = 1'b1;
                end else if (last && hi_ok) begin
                    state_n = OWN;
                    dout_n  = sda_i;
                    scl_n   = 1'b1;
                    done_n  = 1'b1;
                end
            end
            STO_LO: begin
                if (last) begin
                    state_n = STO_SU;
                    cnt_n   = ld(T_SUSO);
                    scl_n   = 1'b0;
                end
            end
            STO_SU: begin
                if (!hi_ok) cnt_n = cnt;
                if (arb_hit) begin
                    state_n = IDLE;
                    arb_n   = 1'b1;
                end else if (last && hi_ok) begin
                    state_n = STO_BUF;
                    cnt_n   = ld(T_BUF);
                    sda_n   = 1'b0;
                end
            end
            STO_BUF: begin
                if (last) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        // losing the bus frees both lines at once
        if (arb_n) begin
            cnt_n = '0;
            scl_n = 1'b0;
            sda_n = 1'b0;
        end
        rdy_n = (state_n == IDLE) || (state_n == OWN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            scl_oe   <= 1'b0;
            sda_oe   <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            arb_lost <= 1'b0;
            dout     <= 1'b1;
            rd       <= 1'b0;
            rs       <= 1'b0;
            rdy_r    <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            scl_oe   <= scl_n;
            sda_oe   <= sda_n;
            done     <= done_n;
            err      <= err_n;
            arb_lost <= arb_n;
            dout     <= dout_n;
            rd       <= rd_n;
            rs       <= rs_n;
            rdy_r    <= rdy_n;
        end
    end

endmodule
